// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core, ROUNDS_PER_CLK Feistel rounds per clock, subkeys K16..K1 by right rotation.
// Optional key parity checking is built when DES_KEY_PARITY_CHECK_EN is defined.
//
// state   | meaning
// S_IDLE  | in_ready high, waiting for a block
// S_ROUND | running Feistel rounds, final cycle applies FP to plain_text
// S_DONE  | out_valid high, plain_text held until out_ready
module des_decrypt_iter #(
  parameter int ROUNDS_PER_CLK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cip_text,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plain_text,
  output logic        busy,
  output logic        key_err
);

  localparam int N = 16 / ROUNDS_PER_CLK;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SBOX_T [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Table entries use DES numbering: position p of a W-bit vector is bit W-p.
  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] o;
    for (int k = 0; k < 64; k++) o[6'(63-k)] = x[6'(64-IP_T[k])];
    return o;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] o;
    for (int k = 0; k < 64; k++) o[6'(63-k)] = x[6'(64-FP_T[k])];
    return o;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] o;
    for (int k = 0; k < 56; k++) o[6'(55-k)] = x[6'(64-PC1_T[k])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] o;
    for (int k = 0; k < 48; k++) o[6'(47-k)] = x[6'(56-PC2_T[k])];
    return o;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] sk);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  six;
    for (int k = 0; k < 48; k++) e[6'(47-k)] = r[5'(32-E_T[k])];
    e = e ^ sk;
    for (int b = 0; b < 8; b++) begin
      six = e[6'(47-6*b) -: 6];
      s[5'(31-4*b) -: 4] = 4'(SBOX_T[b*64 + 16*int'({six[5], six[0]}) + int'(six[4:1])]);
    end
    for (int k = 0; k < 32; k++) o[5'(31-k)] = s[5'(32-P_T[k])];
    return o;
  endfunction

  // Right-rotation that undoes the encrypt schedule's left shift of the previous round.
  function automatic logic [27:0] rotr(input logic [27:0] x, input int rnd);
    if (rnd == 1) return x;
    else if (rnd == 2 || rnd == 9 || rnd == 16) return {x[0], x[27:1]};
    else return {x[1:0], x[27:2]};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t      state_q;
  logic [31:0] l_q, r_q, l_d, r_d, tmp;
  logic [27:0] c_q, d_q, c_d, d_d;
  logic [4:0]  cnt_q;
  logic        in_ready_q, out_valid_q, busy_q;
  logic [63:0] plain_q;
  int          rnd;

  always_comb begin
    l_d = l_q;
    r_d = r_q;
    c_d = c_q;
    d_d = d_q;
    tmp = '0;
    rnd = 0;
    for (int s = 0; s < ROUNDS_PER_CLK; s++) begin
      rnd = int'(cnt_q) * ROUNDS_PER_CLK + s + 1;
      c_d = rotr(c_d, rnd);
      d_d = rotr(d_d, rnd);
      tmp = r_d;
      r_d = l_d ^ feistel(r_d, pc2({c_d, d_d}));
      l_d = tmp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      plain_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid && in_ready_q) begin
          {l_q, r_q}  <= perm_ip(cip_text);
          {c_q, d_q}  <= pc1(key);
          cnt_q       <= '0;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b1;
          state_q     <= S_ROUND;
        end
        S_ROUND: if (cnt_q == 5'(N)) begin
          plain_q     <= key_err ? 64'h0 : perm_fp({r_q, l_q});
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end else begin
          l_q   <= l_d;
          r_q   <= r_d;
          c_q   <= c_d;
          d_q   <= d_d;
          cnt_q <= cnt_q + 5'd1;
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic key_err_q;

  function automatic logic parity_bad(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) bad = bad | ~(^k[6'(8*b) +: 8]);
    return bad;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) key_err_q <= 1'b0;
    else if (state_q == S_IDLE && in_valid && in_ready_q) key_err_q <= parity_bad(key);
  end

  assign key_err = key_err_q;
`else
  assign key_err = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign plain_text = plain_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: three instances (1, 2, 4 rounds per clock) checked against
// known answers and a bit-array DES reference model.
module tb_des_decrypt_iter;

  localparam int RPC_T [3] = '{1, 2, 4};
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1, C1 = 64'h85E813540F0AB405, P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73, C2 = 64'h0000000000000000, P2 = 64'h8787878787878787;

  localparam int IP [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                             57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                             36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                            16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                              63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                              41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  logic        clk, rst;
  logic        in_valid [3];
  logic        out_ready [3];
  logic [63:0] cip_in [3];
  logic [63:0] key_in [3];
  logic        in_ready [3];
  logic        out_valid [3];
  logic        busy [3];
  logic        key_err [3];
  logic [63:0] plain_text [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    des_decrypt_iter #(.ROUNDS_PER_CLK(RPC_T[g])) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .cip_text(cip_in[g]), .key(key_in[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .plain_text(plain_text[g]), .busy(busy[g]), .key_err(key_err[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Textbook DES on 1-indexed bit arrays: forward left-shift schedule, subkeys reversed for decryption.
  function automatic logic [63:0] ref_des(input logic [63:0] kin, input logic [63:0] blk, input bit dec);
    bit kb [1:64];
    bit mb [1:64];
    bit cd [1:56];
    bit tmp [1:56];
    bit l [1:32];
    bit r [1:32];
    bit nr [1:32];
    bit s [1:32];
    bit e [1:48];
    bit t [1:64];
    bit sk [1:16][1:48];
    logic [63:0] o;
    int row, col, v, j;
    for (int i = 1; i <= 64; i++) begin kb[i] = kin[64-i]; mb[i] = blk[64-i]; end
    for (int i = 1; i <= 56; i++) cd[i] = kb[PC1[i-1]];
    for (int n = 1; n <= 16; n++) begin
      tmp = cd;
      for (int i = 1; i <= 28; i++) begin
        cd[i]    = tmp[(i - 1 + SHIFTS[n-1]) % 28 + 1];
        cd[28+i] = tmp[28 + (i - 1 + SHIFTS[n-1]) % 28 + 1];
      end
      for (int i = 1; i <= 48; i++) sk[n][i] = cd[PC2[i-1]];
    end
    for (int i = 1; i <= 32; i++) begin l[i] = mb[IP[i-1]]; r[i] = mb[IP[i+31]]; end
    for (int n = 1; n <= 16; n++) begin
      j = dec ? 17 - n : n;
      for (int i = 1; i <= 48; i++) e[i] = r[E[i-1]] ^ sk[j][i];
      for (int b = 0; b < 8; b++) begin
        row = 2 * int'(e[6*b+1]) + int'(e[6*b+6]);
        col = 8 * int'(e[6*b+2]) + 4 * int'(e[6*b+3]) + 2 * int'(e[6*b+4]) + int'(e[6*b+5]);
        v = SB[b*64 + row*16 + col];
        for (int q = 0; q < 4; q++) s[4*b+1+q] = v[3-q];
      end
      for (int i = 1; i <= 32; i++) nr[i] = l[i] ^ s[P[i-1]];
      l = r;
      r = nr;
    end
    for (int i = 1; i <= 32; i++) begin t[i] = r[i]; t[32+i] = l[i]; end
    for (int i = 1; i <= 64; i++) o[64-i] = t[FP[i-1]];
    return o;
  endfunction

  function automatic logic [63:0] odd_parity(input logic [63:0] k);
    logic [63:0] o;
    o = k;
    for (int b = 0; b < 8; b++) o[8*b] = ~(^k[8*b+1 +: 7]);
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes one block into unit u; returns edges from acceptance to out_valid and the output seen then.
  task automatic drive_block(input int u, input logic [63:0] k, input logic [63:0] c,
                             output int lat, output logic [63:0] pt);
    int guard;
    guard = 0;
    while (!in_ready[u] && guard < 100) begin tick(); guard++; end
    checks++;
    if (in_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait unit %0d: in_ready=%b required 1", u, in_ready[u]);
    end
    in_valid[u] = 1'b1;
    key_in[u]   = k;
    cip_in[u]   = c;
    tick();
    in_valid[u] = 1'b0;
    key_in[u]   = {$urandom, $urandom};
    cip_in[u]   = {$urandom, $urandom};
    lat = 0;
    while (!out_valid[u] && lat < 60) begin tick(); lat++; end
    pt = plain_text[u];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int u = 0; u < 3; u++) begin
      checks++;
      if ({in_ready[u], out_valid[u], busy[u], key_err[u]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_flags unit %0d: rdy/vld/busy/err=%b%b%b%b required 1000",
                 u, in_ready[u], out_valid[u], busy[u], key_err[u]);
      end
      checks++;
      if (plain_text[u] !== 64'h0) begin
        errors++;
        $display("FAIL reset_plain unit %0d: %h required 0", u, plain_text[u]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_known_answer();
    int lat;
    logic [63:0] pt;
    drive_block(0, K1, C1, lat, pt);
    checks++;
    if (pt !== P1) begin errors++; $display("FAIL t1_plain: %h required %h", pt, P1); end
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL t1_latency: %0d required 17", lat); end
  endtask

  task automatic test_rounds_per_clk();
    int lat;
    logic [63:0] pt;
    for (int u = 0; u < 3; u++) begin
      drive_block(u, K2, C2, lat, pt);
      checks++;
      if (pt !== P2) begin errors++; $display("FAIL t2_plain rpc %0d: %h required %h", RPC_T[u], pt, P2); end
      checks++;
      if (lat !== 16 / RPC_T[u] + 1) begin
        errors++;
        $display("FAIL t2_latency rpc %0d: %0d required %0d", RPC_T[u], lat, 16 / RPC_T[u] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] pt;
    out_ready[0] = 1'b0;
    drive_block(0, K1, C1, lat, pt);
    checks++;
    if (pt !== P1) begin errors++; $display("FAIL t3_plain: %h required %h", pt, P1); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (plain_text[0] !== P1 || {out_valid[0], in_ready[0], busy[0]} !== 3'b101) begin
        errors++;
        $display("FAIL t3_stall cycle %0d: plain=%h vld/rdy/busy=%b%b%b required %h 101",
                 i, plain_text[0], out_valid[0], in_ready[0], busy[0], P1);
      end
    end
    out_ready[0] = 1'b1;
    tick();
    checks++;
    if ({out_valid[0], in_ready[0], busy[0]} !== 3'b010) begin
      errors++;
      $display("FAIL t3_release: vld/rdy/busy=%b%b%b required 010", out_valid[0], in_ready[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid_round();
    int lat;
    int guard;
    logic [63:0] pt;
    guard = 0;
    while (!in_ready[0] && guard < 100) begin tick(); guard++; end
    in_valid[0] = 1'b1;
    key_in[0]   = K1;
    cip_in[0]   = C1;
    tick();
    in_valid[0] = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid[0], in_ready[0], busy[0]} !== 3'b010 || plain_text[0] !== 64'h0) begin
      errors++;
      $display("FAIL t4_reset: vld/rdy/busy=%b%b%b plain=%h required 010 0",
               out_valid[0], in_ready[0], busy[0], plain_text[0]);
    end
    drive_block(0, K2, C2, lat, pt);
    checks++;
    if (pt !== P2) begin errors++; $display("FAIL t4_after_reset: %h required %h", pt, P2); end
  endtask

  task automatic test_key_parity();
    int lat;
    logic [63:0] pt;
    logic [63:0] bad_key;
    bad_key = 64'h133457799BBCDFF0;
`ifdef DES_KEY_PARITY_CHECK_EN
    drive_block(1, bad_key, {$urandom, $urandom}, lat, pt);
    checks++;
    if (pt !== 64'h0 || key_err[1] !== 1'b1) begin
      errors++;
      $display("FAIL t5_bad_key: plain=%h key_err=%b required 0 1", pt, key_err[1]);
    end
    tick();
    checks++;
    if (key_err[1] !== 1'b1) begin errors++; $display("FAIL t5_sticky: key_err=%b required 1", key_err[1]); end
    drive_block(1, K1, C1, lat, pt);
    checks++;
    if (pt !== P1 || key_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL t5_good_key: plain=%h key_err=%b required %h 0", pt, key_err[1], P1);
    end
`else
    drive_block(1, bad_key, C1, lat, pt);
    checks++;
    if (pt !== P1 || key_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL t5_parity_ignored: plain=%h key_err=%b required %h 0", pt, key_err[1], P1);
    end
`endif
  endtask

  task automatic test_round_trip();
    int lat;
    int u;
    logic [63:0] k, p, c, pt;
    for (int i = 0; i < 1000; i++) begin
      u = i % 3;
      k = odd_parity({$urandom, $urandom});
      p = {$urandom, $urandom};
      c = ref_des(k, p, 1'b0);
      drive_block(u, k, c, lat, pt);
      checks++;
      if (pt !== p || lat !== 16 / RPC_T[u] + 1) begin
        errors++;
        $display("FAIL t6_round_trip %0d rpc %0d: key=%h cip=%h plain=%h lat=%0d required %h lat %0d",
                 i, RPC_T[u], k, c, pt, lat, p, 16 / RPC_T[u] + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b1;
      cip_in[u]    = '0;
      key_in[u]    = '0;
    end
    test_reset();
    test_known_answer();
    test_rounds_per_clk();
    test_backpressure();
    test_reset_mid_round();
    test_key_parity();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
